// File: rtl/zapper_pkg.sv
// zapper_pkg
//   Shared types for the light-gun receive path.
//   phase_t     : flash frame type requested from the pattern generator.
//   zap_state_t : hit-detector sequencing state, also exported for debug.
//   SHOTS_MAX   : saturation value of the verdict counter.
//   phase_of()  : flash frame type driven while in a given state.
package zapper_pkg;

   typedef enum logic [1:0] {
      PH_NONE  = 2'd0,
      PH_BLACK = 2'd1,
      PH_WHITE = 2'd2
   } phase_t;

   typedef enum logic [2:0] {
      ST_HELD   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_ARM    = 3'd2,
      ST_BLACK  = 3'd3,
      ST_WHITE  = 3'd4,
      ST_RESULT = 3'd5
   } zap_state_t;

   localparam logic [7:0] SHOTS_MAX = 8'd255;

   function automatic phase_t phase_of(input zap_state_t st);
      phase_t ph;
      ph = PH_NONE;
      if (st == ST_BLACK) ph = PH_BLACK;
      if (st == ST_WHITE) ph = PH_WHITE;
      return ph;
   endfunction

endpackage

// File: rtl/zapper_hit_detector_if.sv
// zapper_hit_detector_if
//   Signal bundle between the light-gun detector, the VGA timing block, the
//   gun itself and the pattern generator.
//   frame_start : in  to detector, one-cycle pulse at row 0 / col 0.
//   trigger     : in  to detector, raw asynchronous gun trigger.
//   detect      : in  to detector, raw asynchronous photodiode (1 = light).
//   flash_phase : out of detector, frame type for the pattern generator.
//   busy        : out of detector, high while a flash sequence runs.
//   hit / miss  : out of detector, one-cycle verdict pulses.
//   shots       : out of detector, saturating verdict count.
//   state_dbg   : out of detector, current sequencing state.
//
//   Transfer semantics: there is no valid/ready pair on this bundle. Every
//   pulse (frame_start, hit, miss) is a one-cycle strobe that the receiver
//   must take in the cycle it is high; nothing is ever held or back-pressured.
//   Exactly one of hit/miss is high per completed sequence.
//
//   master : the environment (timing block, gun, pattern generator).
//   slave  : the hit detector.
interface zapper_hit_detector_if;
   import zapper_pkg::*;

   logic       frame_start;
   logic       trigger;
   logic       detect;
   phase_t     flash_phase;
   logic       busy;
   logic       hit;
   logic       miss;
   logic [7:0] shots;
   zap_state_t state_dbg;

   modport master (
      output frame_start, trigger, detect,
      input  flash_phase, busy, hit, miss, shots, state_dbg
   );

   modport slave (
      input  frame_start, trigger, detect,
      output flash_phase, busy, hit, miss, shots, state_dbg
   );

endinterface

// File: rtl/zapper_debounce.sv
// zapper_debounce
//   Two-flop synchronizer and debouncer for the raw gun trigger.
//   clk     : pixel clock.
//   rst     : synchronous, active-high reset.
//   trigger : raw asynchronous trigger input.
//   level   : debounced trigger level (resets to 1).
//   rise    : one-cycle pulse on a debounced 0->1 change.
module zapper_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic trigger,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level_q;

   // The counter holds the number of consecutive cycles the synchronized
   // trigger has disagreed with the debounced level. The level flips on the
   // cycle that count reaches DEBOUNCE_CYCLES. Level and its delayed copy both
   // reset to 1 so a trigger held through reset produces no edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync    <= 2'b00;
         cnt     <= '0;
         level   <= 1'b1;
         level_q <= 1'b1;
      end else begin
         sync    <= {sync[0], trigger};
         level_q <= level;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= ~level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/zapper_hit_detector.sv
// zapper_hit_detector
//   Light-gun receive side. A debounced trigger pull requests one black and
//   one white-target flash frame; the photodiode is measured in each frame
//   and a single hit or miss pulse is issued after the white frame.
//   clk : pixel clock, the only clock.
//   rst : synchronous, active-high reset.
//   zif : zapper_hit_detector_if.slave (frame_start, trigger, detect in;
//         flash_phase, busy, hit, miss, shots, state_dbg out).
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles before the debounced trigger changes.
//     MIN_DETECT      : detect-high cycles per frame that count as light.
//   Build option ZAPPER_DARK_CHECK_EN: when defined, light seen during the
//   black frame marks the shot as a miss. When undefined, detect is ignored
//   during the black frame and the verdict depends on the white frame only.
module zapper_hit_detector
   import zapper_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MIN_DETECT      = 64
) (
   input logic                  clk,
   input logic                  rst,
   zapper_hit_detector_if.slave zif
);

   localparam int LW = $clog2(MIN_DETECT + 1);

   zap_state_t    state;
   zap_state_t    state_next;
   logic          trig_level;
   logic          trig_rise;
   logic [1:0]    det_sync;
   logic          det_s;
   logic          det_count;
   logic [LW-1:0] light_cnt;
   logic          light_sat;
   logic          enter_black;
   logic          enter_white;
   logic          lit;
   logic          dark_fail;
   logic          good_shot;
   logic [7:0]    shots;

   zapper_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .trigger (zif.trigger),
      .level   (trig_level),
      .rise    (trig_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) det_sync <= 2'b00;
      else     det_sync <= {det_sync[0], zif.detect};
   end
   assign det_s = det_sync[1];

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= ST_HELD;
      else     state <= state_next;
   end

   // HELD waits for a release, so a press that is still down after a
   // sequence (or through reset) can never start another one.
   always_comb begin
      state_next = state;
      case (state)
         ST_HELD:   if (!trig_level)     state_next = ST_IDLE;
         ST_IDLE:   if (trig_rise)       state_next = ST_ARM;
         ST_ARM:    if (zif.frame_start) state_next = ST_BLACK;
         ST_BLACK:  if (zif.frame_start) state_next = ST_WHITE;
         ST_WHITE:  if (zif.frame_start) state_next = ST_RESULT;
         ST_RESULT:                      state_next = ST_HELD;
         default:                        state_next = ST_HELD;
      endcase
   end

   assign enter_black = (state != ST_BLACK) && (state_next == ST_BLACK);
   assign enter_white = (state != ST_WHITE) && (state_next == ST_WHITE);

   // ---------------- light measurement ----------------
`ifdef ZAPPER_DARK_CHECK_EN
   assign det_count = det_s;
`else
   assign det_count = det_s && (state != ST_BLACK);
`endif

   assign light_sat = (light_cnt == LW'(MIN_DETECT));

   always_ff @(posedge clk) begin
      if (rst) begin
         light_cnt <= '0;
      end else if (enter_black || enter_white) begin
         light_cnt <= '0;
      end else if (det_count && !light_sat) begin
         light_cnt <= light_cnt + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                lit <= 1'b0;
      else if (enter_white)                   lit <= 1'b0;
      else if (state == ST_WHITE && light_sat) lit <= 1'b1;
   end

`ifdef ZAPPER_DARK_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                                dark_fail <= 1'b0;
      else if (enter_black)                   dark_fail <= 1'b0;
      else if (state == ST_BLACK && light_sat) dark_fail <= 1'b1;
   end
`else
   assign dark_fail = 1'b0;
`endif

   // ---------------- verdict ----------------
   assign good_shot = lit && !dark_fail;

   // The count moves on the edge into RESULT so it already includes the
   // verdict being pulsed.
   always_ff @(posedge clk) begin
      if (rst) begin
         shots <= 8'd0;
      end else if (state == ST_WHITE && state_next == ST_RESULT && shots != SHOTS_MAX) begin
         shots <= shots + 8'd1;
      end
   end

   assign zif.flash_phase = phase_of(state);
   assign zif.busy        = (state == ST_ARM) || (state == ST_BLACK) || (state == ST_WHITE);
   assign zif.hit         = (state == ST_RESULT) && good_shot;
   assign zif.miss        = (state == ST_RESULT) && !good_shot;
   assign zif.shots       = shots;
   assign zif.state_dbg   = state;

endmodule

// File: tb/tb_zapper_hit_detector.sv
module tb_zapper_hit_detector;
  import zapper_pkg::*;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int MIN_DETECT      = 3;
  localparam int FRAME_LEN       = 20;
`ifdef ZAPPER_DARK_CHECK_EN
  localparam bit DARK_EN = 1'b1;
`else
  localparam bit DARK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zapper_hit_detector_if zif();

  zapper_hit_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MIN_DETECT(MIN_DETECT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .zif(zif.slave)
  );

  int errors      = 0;
  int checks      = 0;
  int verdicts    = 0;
  int fcnt        = 0;
  int shots_model = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    int    blk;
    int    wht;
    bit    repress;
    bit    exp_hit;
    string name;
  } vec_t;
  vec_t tbl[6];

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are read 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    fcnt = (fcnt == FRAME_LEN - 1) ? 0 : fcnt + 1;
    zif.frame_start = (fcnt == 0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int n;
    n = 0;
    while (int'(zif.flash_phase) != ph && n < 80) begin
      step();
      n++;
    end
    check(name, int'(zif.flash_phase), ph);
  endtask

  // One frame's worth of detect (and optional re-press) starting at the
  // first cycle of the frame; light sits well inside the frame.
  task automatic run_frame(input int n_det, input bit repress);
    for (int i = 0; i < FRAME_LEN - 2; i++) begin
      zif.detect = (i >= 2 && i < 2 + n_det);
      if (repress) zif.trigger = !(i >= 1 && i < 8);
      step();
    end
    zif.detect = 1'b0;
  endtask

  // Reference: a frame sees light when it holds at least MIN_DETECT high
  // detect cycles; the shot hits when the white frame saw light and, with
  // the dark check on, the black frame did not.
  function automatic bit model_hit(input int blk, input int wht);
    return (wht >= MIN_DETECT) && !(DARK_EN && blk >= MIN_DETECT);
  endfunction

  task automatic do_shot(input int blk, input int wht, input bit repress,
                         input bit exp_hit, input string name);
    int v0;
    int n;
    zif.trigger = 1'b0;
    zif.detect  = 1'b0;
    repeat (8) step();
    zif.trigger = 1'b1;
    wait_phase(1, {name, "_phase_black"});
    check({name, "_busy_black"}, int'(zif.busy), 1);
    run_frame(blk, 1'b0);
    wait_phase(2, {name, "_phase_white"});
    check({name, "_busy_white"}, int'(zif.busy), 1);
    v0 = verdicts;
    exp_q.push_back(exp_hit);
    run_frame(wht, repress);
    zif.trigger = 1'b1;
    n = 0;
    while (verdicts == v0 && n < 40) begin
      step();
      n++;
    end
    if (verdicts == v0) exp_q.delete();
    else if (shots_model < 255) shots_model++;
    repeat (25) step();
    check({name, "_verdict_count"}, verdicts - v0, 1);
    check({name, "_shots"}, int'(zif.shots), shots_model);
    check({name, "_phase_after"}, int'(zif.flash_phase), 0);
    check({name, "_busy_after"}, int'(zif.busy), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [0:0] e;
    #2;
    if (zif.hit || zif.miss) begin
      verdicts++;
      checks++;
      if (zif.hit && zif.miss) begin
        errors++;
        $display("FAIL verdict_both: hit=%0b miss=%0b, required exactly one", zif.hit, zif.miss);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL verdict_unexpected: hit=%0b miss=%0b, required no pulse", zif.hit, zif.miss);
      end else begin
        e = exp_q.pop_front();
        if (zif.hit !== e[0]) begin
          errors++;
          $display("FAIL verdict_value: hit=%0b expected hit=%0b", zif.hit, e[0]);
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int bad;
    int b;
    int w;

    tbl[0] = '{blk: 0, wht: 5, repress: 1'b0, exp_hit: 1'b1, name: "white5"};
    tbl[1] = '{blk: 0, wht: 2, repress: 1'b0, exp_hit: 1'b0, name: "white2"};
    tbl[2] = '{blk: 0, wht: 3, repress: 1'b0, exp_hit: 1'b1, name: "white3_edge"};
`ifdef ZAPPER_DARK_CHECK_EN
    tbl[3] = '{blk: 5, wht: 5, repress: 1'b0, exp_hit: 1'b0, name: "lamp5"};
    tbl[4] = '{blk: 3, wht: 3, repress: 1'b0, exp_hit: 1'b0, name: "lamp3_edge"};
`else
    tbl[3] = '{blk: 5, wht: 5, repress: 1'b0, exp_hit: 1'b1, name: "lamp5"};
    tbl[4] = '{blk: 3, wht: 3, repress: 1'b0, exp_hit: 1'b1, name: "lamp3_edge"};
`endif
    tbl[5] = '{blk: 0, wht: 5, repress: 1'b1, exp_hit: 1'b1, name: "repress_white"};

    rst             = 1'b1;
    zif.trigger     = 1'b1;
    zif.detect      = 1'b0;
    zif.frame_start = 1'b0;
    repeat (3) step();

    // Reset state with the trigger held.
    check("rst_phase", int'(zif.flash_phase), 0);
    check("rst_busy", int'(zif.busy), 0);
    check("rst_shots", int'(zif.shots), 0);
    check("rst_state", int'(zif.state_dbg), int'(ST_HELD));

    // Trigger held after reset must never start a sequence.
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (zif.busy || zif.flash_phase != PH_NONE || zif.state_dbg != ST_HELD) bad++;
    end
    check("held_bad_cycles", bad, 0);

    // Short glitch after release: not long enough to debounce.
    zif.trigger = 1'b0;
    repeat (10) step();
    zif.trigger = 1'b1;
    repeat (2) step();
    zif.trigger = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (zif.busy) bad++;
    end
    check("glitch_busy_cycles", bad, 0);
    check("glitch_state", int'(zif.state_dbg), int'(ST_IDLE));

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      do_shot(tbl[i].blk, tbl[i].wht, tbl[i].repress, tbl[i].exp_hit, tbl[i].name);

    // Randomized shots against the reference.
    for (int i = 0; i < 8; i++) begin
      b = $urandom_range(0, 8);
      w = $urandom_range(0, 8);
      do_shot(b, w, 1'b0, model_hit(b, w), "rand");
    end

    // Reset in the middle of the white frame.
    zif.trigger = 1'b0;
    repeat (8) step();
    zif.trigger = 1'b1;
    wait_phase(1, "rstmid_phase_black");
    run_frame(0, 1'b0);
    wait_phase(2, "rstmid_phase_white");
    zif.detect = 1'b1;
    repeat (5) step();
    b = verdicts;
    rst = 1'b1;
    step();
    check("rstmid_phase", int'(zif.flash_phase), 0);
    check("rstmid_busy", int'(zif.busy), 0);
    check("rstmid_shots", int'(zif.shots), 0);
    check("rstmid_state", int'(zif.state_dbg), int'(ST_HELD));
    rst = 1'b0;
    zif.detect = 1'b0;
    shots_model = 0;
    repeat (40) step();
    check("rstmid_no_verdict", verdicts - b, 0);

    // Counting restarts from zero after reset.
    do_shot(0, 6, 1'b0, 1'b1, "after_rst");

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zapper_hit_detector.md
# zapper_hit_detector

Light-gun receive side for the Duck Hunt display path. On a debounced trigger pull it asks the pattern generator for a two-frame flash sequence: one black frame, then one white-target frame. During those frames it measures the photodiode `detect` input and issues a single-cycle `hit` or `miss` verdict. It sits beside the pattern generator, clocked by the pixel clock, and uses the per-frame start pulse from the VGA timing block.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 — cycles the raw trigger must stay stable before the debounced level changes (10 ms at 25 MHz).
- `MIN_DETECT`, default 64 — synchronized `detect`-high cycles within one frame that count as "light seen".

Ports (clock and reset first):
- `clk` in 1 — pixel clock; the only clock.
- `rst` in 1 — synchronous, active-high reset.
- `frame_start` in 1 — one-cycle pulse at row 0, col 0 of every frame.
- `trigger` in 1 — raw gun trigger, asynchronous, active-high.
- `detect` in 1 — raw photodiode output, asynchronous, active-high = light.
- `flash_phase` out 2 — flash frame type for the pattern generator: 0 NONE, 1 BLACK, 2 WHITE.
- `busy` out 1 — high in ARM, BLACK, WHITE.
- `hit` out 1 — one-cycle pulse: target seen.
- `miss` out 1 — one-cycle pulse: no target, or dark-check failure.
- `shots` out 8 — count of verdicts issued, saturating at 255.

## Operation
- **Input synchronizers**
  - `trigger` and `detect` each pass through 2 flops; reset value is 0.
- **Trigger debounce**
  - Counter reloads whenever the synchronized trigger equals the debounced level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level toggles.
  - The debounced level resets to 1, so a trigger held through reset never fires.
- **FSM states:** HELD, IDLE, ARM, BLACK, WHITE, RESULT. Reset state is HELD.
  - HELD → IDLE when the debounced trigger is 0.
  - IDLE → ARM on a debounced-trigger 0→1 edge.
  - ARM → BLACK on `frame_start`.
  - BLACK → WHITE on `frame_start`.
  - WHITE → RESULT on `frame_start`.
  - RESULT → HELD unconditionally after 1 cycle.
- **Light counter**
  - Width `$clog2(MIN_DETECT+1)`; counts synchronized `detect`-high cycles, saturating at `MIN_DETECT`.
  - Cleared on entry to BLACK and on entry to WHITE.
  - `dark_fail` flag is set when the counter saturates in BLACK and cleared on entry to BLACK.
  - `lit` flag is set when the counter saturates in WHITE and cleared on entry to WHITE.
- **Verdict in RESULT**
  - `hit` = `lit` AND NOT `dark_fail`; `miss` = its complement. Exactly one of the two pulses.
  - `shots` increments in the same cycle and holds at 255.
- **Outputs**
  - `flash_phase` = BLACK in BLACK, WHITE in WHITE, NONE otherwise.
  - Trigger release during ARM/BLACK/WHITE does not abort the sequence.
  - A new trigger edge during a sequence is ignored, because HELD requires release.

## Timing
- Reset values: `flash_phase`=0, `busy`=0, `hit`=0, `miss`=0, `shots`=0, all counters 0, debounced trigger 1.
- Trigger latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycle to reach ARM.
- State changes happen at the edge where `frame_start`=1, so `flash_phase` is valid from the cycle after the pulse for the whole frame.
- `detect` is counted 2 cycles late because of the synchronizer. The last 2 cycles of light from a frame land in the next state; this is accepted.
- `hit`/`miss` pulse in the cycle after the `frame_start` that ends WHITE.
- `frame_start` in the same cycle as the trigger edge: IDLE→ARM only; BLACK starts at the next pulse.
- `rst` mid-sequence: return to HELD next cycle, `flash_phase`=0, no verdict pulse, `shots` cleared.

## Configuration
- Macro: `ZAPPER_DARK_CHECK_EN`.
- Defined: `dark_fail` is computed as above, and a lamp pointed at the screen scores a miss.
- Undefined: BLACK is still sequenced and output, but `detect` is ignored there, `dark_fail` is tied to 0, and `hit` = `lit`.

## Structure
- Package `zapper_pkg`:
  - `phase_t` enum (PH_NONE=0, PH_BLACK=1, PH_WHITE=2), shared with the pattern generator.
  - `zap_state_t` enum.
  - Localparam `SHOTS_MAX`=255.
- Sub-module `zapper_debounce`: synchronizer, debounce counter, debounced level, and rising-edge output. The top-level module holds the FSM, light counter, and verdict logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `MIN_DETECT`=3, and 20-cycle frames.
- Trigger held high through and after `rst` for 50 cycles → stays HELD; no `busy`, no verdict.
- Trigger release ≥6 cycles, then press ≥6 cycles; `detect` low in BLACK, high for 5 cycles in WHITE → `flash_phase` sequence 1 then 2, then `hit`=1 for 1 cycle, `shots`=1.
- Same press, `detect` high for only 2 cycles in WHITE → `miss` pulse, `shots`=1.
- `detect` high for 5 cycles in BLACK and 5 in WHITE → `miss` with `ZAPPER_DARK_CHECK_EN` defined; `hit` with it undefined.
- Trigger glitch high for 2 cycles → no ARM. Second press while in WHITE → ignored, exactly one verdict.
- `rst` asserted during WHITE → next cycle `flash_phase`=0, `busy`=0, no `hit`/`miss`, `shots`=0.
